// File: rtl/ring_router_rr.sv
// One node of a bidirectional ring NoC: three input FIFOs, shortest-path
// injection, through/local output arbitration and a valid/ready eject port.
module ring_router_rr #(
  parameter int NUM_NODES        = 4,
  parameter int ROUTER_ID        = 0,
  parameter int TS_W             = 16,
  parameter int ID_W             = 16,
  parameter int PACKET_SIZE      = 1 + TS_W + 2*ID_W,
  parameter int BUFFER_SIZE      = 4,
  parameter int BUFFER_THRESHOLD = 2,
  parameter int ARB_MODE         = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [TS_W-1:0]        clk_counter,
  input  logic [PACKET_SIZE-1:0] link_east_in,
  input  logic [PACKET_SIZE-1:0] link_west_in,
  input  logic                   backpressure_east_rd,
  input  logic                   backpressure_west_rd,
  output logic [PACKET_SIZE-1:0] link_east_out,
  output logic [PACKET_SIZE-1:0] link_west_out,
  output logic                   backpressure_east_wr,
  output logic                   backpressure_west_wr,
  input  logic                   inject_valid,
  input  logic [PACKET_SIZE-1:0] inject_packet,
  output logic                   inject_ready,
  output logic                   eject_valid,
  output logic [PACKET_SIZE-1:0] eject_packet,
  input  logic                   eject_ready,
  output logic [63:0]            total_packet_recieve,
  output logic [63:0]            total_latency,
  output logic [63:0]            total_packet_dropped
);

  localparam int  PW     = PACKET_SIZE;
  localparam int  AW     = $clog2(BUFFER_SIZE);
  localparam int  TS_LSB = 2*ID_W;
  localparam bit  RR     = (ARB_MODE != 0);

  // index 0 = E (from east link), 1 = W (from west link), 2 = L (inject)
  logic [PW-1:0] mem [3][BUFFER_SIZE];
  logic [AW:0]   wr_ptr [3];
  logic [AW:0]   rd_ptr [3];
  logic [AW:0]   cnt    [3];
  logic [AW:0]   cnt_nx [3];
  logic [PW-1:0] wdata  [3];
  logic [PW-1:0] head   [3];
  logic [2:0]    full, empty, push, pop;
  logic [1:0]    drop;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt[i]   = wr_ptr[i] - rd_ptr[i];
      full[i]  = (cnt[i] == (AW+1)'(BUFFER_SIZE));
      empty[i] = (cnt[i] == '0);
      head[i]  = mem[i][rd_ptr[i][AW-1:0]];
    end
  end

  assign wdata[0] = link_east_in;
  assign wdata[1] = link_west_in;
  assign wdata[2] = {inject_packet[PW-1] | 1'b1, inject_packet[PW-2:0]};

  assign inject_ready = !full[2];

  // a full FIFO still accepts when its head leaves this cycle
  assign push[0] = link_east_in[PW-1] && (!full[0] || pop[0]);
  assign push[1] = link_west_in[PW-1] && (!full[1] || pop[1]);
  assign push[2] = inject_valid && !full[2];
  assign drop[0] = link_east_in[PW-1] && full[0] && !pop[0];
  assign drop[1] = link_west_in[PW-1] && full[1] && !pop[1];

  always_comb begin
    for (int i = 0; i < 3; i++)
      cnt_nx[i] = cnt[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
  end

  logic        e_ej, e_thru, w_ej, w_thru;
  logic        l_ej, l_east, l_west;
  logic [31:0] d_l;

  assign e_ej   = !empty[0] && (head[0][ID_W-1:0] == ID_W'(ROUTER_ID));
  assign e_thru = !empty[0] && !e_ej;
  assign w_ej   = !empty[1] && (head[1][ID_W-1:0] == ID_W'(ROUTER_ID));
  assign w_thru = !empty[1] && !w_ej;

  assign d_l = (32'(head[2][ID_W-1:0]) + 32'(NUM_NODES)
               - 32'(ROUTER_ID)) % 32'(NUM_NODES);
  assign l_ej   = !empty[2] && (d_l == 32'd0);
  assign l_east = !empty[2] && (d_l != 32'd0)
                  && (d_l <= 32'(NUM_NODES/2));
  assign l_west = !empty[2] && (d_l > 32'(NUM_NODES/2));

  // rr pointer: 0 favours through traffic, 1 favours local
  logic rr_e, rr_w;
  logic gnt_e_t, gnt_e_l, gnt_w_t, gnt_w_l;

  assign gnt_e_t = !backpressure_east_rd && w_thru
                   && (!l_east || !RR || !rr_e);
  assign gnt_e_l = !backpressure_east_rd && l_east
                   && (!w_thru || (RR && rr_e));
  assign gnt_w_t = !backpressure_west_rd && e_thru
                   && (!l_west || !RR || !rr_w);
  assign gnt_w_l = !backpressure_west_rd && l_west
                   && (!e_thru || (RR && rr_w));

  logic          ej_load;
  logic [2:0]    ej_req, ej_gnt;
  logic [1:0]    ej_ptr, ej_nxt;
  logic [PW-1:0] ej_data;

  assign ej_load = !eject_valid || eject_ready;
  assign ej_req  = {l_ej, w_ej, e_ej};

  always_comb begin
    ej_gnt = '0;
    ej_nxt = ej_ptr;
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (int'(ej_ptr) + k) % 3;
      if (ej_load && (ej_gnt == 3'b000) && ej_req[idx]) begin
        ej_gnt[idx] = 1'b1;
        ej_nxt      = 2'((idx + 1) % 3);
      end
    end
  end

  always_comb begin
    unique case (1'b1)
      ej_gnt[0]: ej_data = head[0];
      ej_gnt[1]: ej_data = head[1];
      ej_gnt[2]: ej_data = head[2];
      default:   ej_data = '0;
    endcase
  end

  assign pop[0] = gnt_w_t || ej_gnt[0];
  assign pop[1] = gnt_e_t || ej_gnt[1];
  assign pop[2] = gnt_e_l || gnt_w_l || ej_gnt[2];

  logic [PW-1:0] east_nx, west_nx;

  always_comb begin
    unique case (1'b1)
      gnt_e_t: east_nx = head[1];
      gnt_e_l: east_nx = head[2];
      default: east_nx = '0;
    endcase
    unique case (1'b1)
      gnt_w_t: west_nx = head[0];
      gnt_w_l: west_nx = head[2];
      default: west_nx = '0;
    endcase
  end

  logic [TS_W-1:0] lat;
  assign lat = clk_counter - eject_packet[TS_LSB +: TS_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= wdata[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      link_east_out        <= '0;
      link_west_out        <= '0;
      backpressure_east_wr <= 1'b0;
      backpressure_west_wr <= 1'b0;
      rr_e                 <= 1'b0;
      rr_w                 <= 1'b0;
      ej_ptr               <= 2'd0;
      eject_valid          <= 1'b0;
      eject_packet         <= '0;
      total_packet_recieve <= '0;
      total_latency        <= '0;
      total_packet_dropped <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
      link_east_out <= east_nx;
      link_west_out <= west_nx;
      backpressure_east_wr <=
        int'(cnt_nx[0]) >= BUFFER_SIZE - BUFFER_THRESHOLD;
      backpressure_west_wr <=
        int'(cnt_nx[1]) >= BUFFER_SIZE - BUFFER_THRESHOLD;
      if (gnt_e_t) rr_e <= 1'b1;
      if (gnt_e_l) rr_e <= 1'b0;
      if (gnt_w_t) rr_w <= 1'b1;
      if (gnt_w_l) rr_w <= 1'b0;
      ej_ptr <= ej_nxt;
      if (ej_load) begin
        eject_valid <= |ej_gnt;
        if (|ej_gnt) eject_packet <= ej_data;
      end
      if (eject_valid && eject_ready) begin
        total_packet_recieve <= total_packet_recieve + 64'd1;
        total_latency        <= total_latency + 64'(lat);
      end
      total_packet_dropped <= total_packet_dropped
                              + 64'(drop[0]) + 64'(drop[1]);
    end
  end

endmodule

// File: tb/tb_ring_router_rr.sv
// Directed bench for ring_router_rr at node 1 of a 4-node ring,
// round-robin instance plus a fixed-priority twin for arbitration.
module tb_ring_router_rr;

  localparam int NN   = 4;
  localparam int RID  = 1;
  localparam int TS_W = 16;
  localparam int ID_W = 16;
  localparam int PS   = 1 + TS_W + 2*ID_W;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [TS_W-1:0] clk_counter;
  logic [PS-1:0]   link_east_in, link_west_in, inject_packet;
  logic            backpressure_east_rd, backpressure_west_rd;
  logic            inject_valid, eject_ready;

  logic [PS-1:0] link_east_out, link_west_out, eject_packet;
  logic          backpressure_east_wr, backpressure_west_wr;
  logic          inject_ready, eject_valid;
  logic [63:0]   total_packet_recieve, total_latency;
  logic [63:0]   total_packet_dropped;

  logic [PS-1:0] link_east_out_0, link_west_out_0, eject_packet_0;
  logic          backpressure_east_wr_0, backpressure_west_wr_0;
  logic          inject_ready_0, eject_valid_0;
  logic [63:0]   total_packet_recieve_0, total_latency_0;
  logic [63:0]   total_packet_dropped_0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ring_router_rr #(
    .NUM_NODES(NN), .ROUTER_ID(RID), .TS_W(TS_W), .ID_W(ID_W),
    .BUFFER_SIZE(4), .BUFFER_THRESHOLD(2), .ARB_MODE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_counter(clk_counter),
    .link_east_in(link_east_in), .link_west_in(link_west_in),
    .backpressure_east_rd(backpressure_east_rd),
    .backpressure_west_rd(backpressure_west_rd),
    .link_east_out(link_east_out), .link_west_out(link_west_out),
    .backpressure_east_wr(backpressure_east_wr),
    .backpressure_west_wr(backpressure_west_wr),
    .inject_valid(inject_valid), .inject_packet(inject_packet),
    .inject_ready(inject_ready), .eject_valid(eject_valid),
    .eject_packet(eject_packet), .eject_ready(eject_ready),
    .total_packet_recieve(total_packet_recieve),
    .total_latency(total_latency),
    .total_packet_dropped(total_packet_dropped)
  );

  ring_router_rr #(
    .NUM_NODES(NN), .ROUTER_ID(RID), .TS_W(TS_W), .ID_W(ID_W),
    .BUFFER_SIZE(4), .BUFFER_THRESHOLD(2), .ARB_MODE(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .clk_counter(clk_counter),
    .link_east_in(link_east_in), .link_west_in(link_west_in),
    .backpressure_east_rd(backpressure_east_rd),
    .backpressure_west_rd(backpressure_west_rd),
    .link_east_out(link_east_out_0), .link_west_out(link_west_out_0),
    .backpressure_east_wr(backpressure_east_wr_0),
    .backpressure_west_wr(backpressure_west_wr_0),
    .inject_valid(inject_valid), .inject_packet(inject_packet),
    .inject_ready(inject_ready_0), .eject_valid(eject_valid_0),
    .eject_packet(eject_packet_0), .eject_ready(eject_ready),
    .total_packet_recieve(total_packet_recieve_0),
    .total_latency(total_latency_0),
    .total_packet_dropped(total_packet_dropped_0)
  );

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PS-1:0] mk(logic v, logic [15:0] ts,
                                       logic [15:0] s, logic [15:0] d);
    return {v, ts, s, d};
  endfunction

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  logic [PS-1:0] t_flit, l_flit, held;
  logic [15:0]   dst_tab [3];
  logic          east_tab [3];

  initial begin
    rst_n = 1'b0;
    clk_counter = '0;
    link_east_in = '0;
    link_west_in = '0;
    inject_packet = '0;
    inject_valid = 1'b0;
    backpressure_east_rd = 1'b0;
    backpressure_west_rd = 1'b0;
    eject_ready = 1'b1;
    tick();
    tick();
    check("rst_east_out", link_east_out, '0);
    check("rst_west_out", link_west_out, '0);
    check("rst_bp", {backpressure_east_wr, backpressure_west_wr}, '0);
    check("rst_ej_valid", eject_valid, '0);
    check("rst_ej_pkt", eject_packet, '0);
    check("rst_recv", total_packet_recieve, '0);
    check("rst_lat", total_latency, '0);
    check("rst_drop", total_packet_dropped, '0);
    rst_n = 1'b1;

    // through flit east->west, 2-cycle latency, no repeat
    link_east_in = mk(1'b1, 16'h0011, 16'h0002, 16'h0003);
    tick();
    link_east_in = '0;
    check("thru_early", link_west_out, '0);
    tick();
    check("thru_west", link_west_out, mk(1'b1, 16'h0011, 16'h2, 16'h3));
    check("thru_east_idle", link_east_out, '0);
    tick();
    check("thru_norepeat", link_west_out, '0);

    // injection steering from node 1
    dst_tab  = '{16'd2, 16'd0, 16'd3};
    east_tab = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      check($sformatf("inj_ready%0d", i), inject_ready, 1'b1);
      inject_valid  = 1'b1;
      inject_packet = mk(1'b0, 16'h0020, 16'h0001, dst_tab[i]);
      tick();
      inject_valid = 1'b0;
      tick();
      check($sformatf("inj_east%0d", i), link_east_out,
            east_tab[i] ? mk(1'b1, 16'h20, 16'h1, dst_tab[i]) : '0);
      check($sformatf("inj_west%0d", i), link_west_out,
            east_tab[i] ? '0 : mk(1'b1, 16'h20, 16'h1, dst_tab[i]));
    end
    inject_valid  = 1'b1;
    inject_packet = mk(1'b0, 16'h0000, 16'h0001, 16'h0001);
    tick();
    inject_valid = 1'b0;
    tick();
    check("loc_ej_valid", eject_valid, 1'b1);
    check("loc_ej_pkt", eject_packet, mk(1'b1, 16'h0, 16'h1, 16'h1));
    tick();
    check("loc_ej_recv", total_packet_recieve, 64'd1);
    check("loc_ej_done", eject_valid, 1'b0);

    // stall west output, fill E FIFO, overflow, then drain in order
    backpressure_west_rd = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      link_east_in = mk(1'b1, 16'(k), 16'h0002, 16'h0003);
      tick();
      if (k == 1) check("bp_after1", backpressure_east_wr, 1'b0);
      if (k == 2) check("bp_after2", backpressure_east_wr, 1'b1);
    end
    link_east_in = '0;
    check("drop_count", total_packet_dropped, 64'd1);
    backpressure_west_rd = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("drain%0d", k), link_west_out,
            mk(1'b1, 16'(k), 16'h0002, 16'h0003));
    end
    tick();
    check("drain_end", link_west_out, '0);

    // through vs local contention on the east port
    pulse_reset();
    t_flit = mk(1'b1, 16'h0000, 16'h00AA, 16'h0003);
    l_flit = mk(1'b1, 16'h0000, 16'h0001, 16'h0002);
    link_west_in  = t_flit;
    inject_valid  = 1'b1;
    inject_packet = mk(1'b0, 16'h0000, 16'h0001, 16'h0002);
    tick();
    for (int c = 1; c <= 6; c++) begin
      tick();
      check($sformatf("rr_grant%0d", c), link_east_out,
            (c % 2 == 1) ? t_flit : l_flit);
      check($sformatf("fp_grant%0d", c), link_east_out_0, t_flit);
    end
    link_west_in = '0;
    inject_valid = 1'b0;

    // held eject with timestamp wrap
    pulse_reset();
    eject_ready  = 1'b0;
    held         = mk(1'b1, 16'hFFFE, 16'h0002, 16'h0001);
    link_east_in = held;
    tick();
    link_east_in = '0;
    tick();
    for (int s = 0; s < 3; s++) begin
      check($sformatf("ej_hold_v%0d", s), eject_valid, 1'b1);
      check($sformatf("ej_hold_p%0d", s), eject_packet, held);
      if (s < 2) tick();
    end
    clk_counter = 16'h0003;
    eject_ready = 1'b1;
    tick();
    check("lat_wrap", total_latency, 64'd5);
    check("lat_recv", total_packet_recieve, 64'd1);

    // asynchronous reset with traffic in flight
    backpressure_east_rd = 1'b1;
    backpressure_west_rd = 1'b1;
    eject_ready  = 1'b0;
    link_east_in = mk(1'b1, 16'h0007, 16'h0002, 16'h0003);
    link_west_in = mk(1'b1, 16'h0009, 16'h0003, 16'h0001);
    tick();
    link_west_in = '0;
    tick();
    link_east_in = '0;
    check("pre_bp", backpressure_east_wr, 1'b1);
    check("pre_ej", eject_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_east_out", link_east_out, '0);
    check("ar_west_out", link_west_out, '0);
    check("ar_bp", {backpressure_east_wr, backpressure_west_wr}, '0);
    check("ar_ej_valid", eject_valid, '0);
    check("ar_ej_pkt", eject_packet, '0);
    check("ar_recv", total_packet_recieve, '0);
    check("ar_lat", total_latency, '0);
    check("ar_drop", total_packet_dropped, '0);
    rst_n = 1'b1;
    backpressure_east_rd = 1'b0;
    backpressure_west_rd = 1'b0;
    eject_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("post_west%0d", c), link_west_out, '0);
      check($sformatf("post_ej%0d", c), eject_valid, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_router_rr.md
Name: ring_router_rr

Overview:
- Parametrised successor of the ring router: one node of a bidirectional ring NoC.
- Input FIFOs with real read/write pointers, registered link outputs and registered threshold backpressure.
- Shortest-path injection steering, selectable fixed-priority or round-robin output arbitration.
- Valid/ready local inject and eject ports; delivery, latency and drop statistics.
- Instantiated NUM_NODES times by the ring top, neighbours wired east/west.

Parameters:
- NUM_NODES, 4, ring size (>=2).
- ROUTER_ID, 0, this node's id (0..NUM_NODES-1).
- TS_W, 16, timestamp field width.
- ID_W, 16, source/destination id width.
- PACKET_SIZE, 1+TS_W+2*ID_W, flit layout {valid, timestamp, src, dst}, dst in LSBs.
- BUFFER_SIZE, 4, depth of each input FIFO (power of 2, >=2).
- BUFFER_THRESHOLD, 2, free-entry level at or below which backpressure asserts (>=2).
- ARB_MODE, 1, 0 = through traffic beats local, 1 = round-robin through/local.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clk_counter  in  TS_W  global time, used for latency.
- link_east_in, link_west_in  in  PACKET_SIZE  flits from neighbours; bit MSB = valid.
- backpressure_east_rd, backpressure_west_rd  in  1  downstream neighbour stall.
- link_east_out, link_west_out  out  PACKET_SIZE  registered flits to neighbours.
- backpressure_east_wr, backpressure_west_wr  out  1  stall to upstream neighbour.
- inject_valid  in  1  local packet offered.
- inject_packet  in  PACKET_SIZE  local packet (valid bit ignored, forced 1 on write).
- inject_ready  out  1  local FIFO not full (combinational).
- eject_valid  out  1  delivered packet present.
- eject_packet  out  PACKET_SIZE  delivered packet.
- eject_ready  in  1  sink accepts.
- total_packet_recieve, total_latency, total_packet_dropped  out  64  statistics.

Behaviour:
- Reset (async, any time, mid-transfer included): all FIFOs empty, pointers 0. link_*_out = 0, backpressure_*_wr = 0, eject_valid = 0, eject_packet = 0, all counters 0. Arbiter pointers select through traffic.
- Three FIFOs: E (fed by link_east_in), W (fed by link_west_in), L (fed by inject).
- Link flit with valid = 1 is written at the clock edge. If its FIFO is full, the flit is discarded and total_packet_dropped increments; simultaneous pop that cycle makes room, so no drop.
- Inject handshake is inject_valid && inject_ready.
- Routing of E/W heads: dst == ROUTER_ID goes to eject. Otherwise the flit continues the same direction: E head goes to west output, W head goes to east output.
- Routing of L head: d = (dst - ROUTER_ID) mod NUM_NODES. d == 0 goes to eject. d <= NUM_NODES/2 goes east, else west; a tie goes east.
- Per output port: candidates are the through head and the L head routed there. The port is granted only if the corresponding backpressure_*_rd = 0.
- ARB_MODE 0: through always wins.
- ARB_MODE 1: round-robin pointer toggles to the other requester after each grant; a lone requester always wins.
- Granted flit is popped and registered onto link_*_out with valid = 1. With no grant, link_*_out = 0 that cycle; a flit is never repeated.
- Eject: candidates are E, W and L heads routed to eject, round-robin E->W->L. The eject register loads when empty or handshaking (eject_valid && eject_ready). eject_valid/eject_packet hold stable while eject_valid && !eject_ready.
- One pop per FIFO per cycle. The L head requests exactly one destination, so no double grant is possible.
- Latency: a link flit written at edge N appears on link_*_out after edge N+1 (2 cycles port-to-port) when uncontended. Inject-to-link latency is also 2 cycles.
- backpressure_*_wr registered: 1 when free entries of its FIFO after this cycle's push/pop <= BUFFER_THRESHOLD, else 0.
- Counters update on eject handshake: total_packet_recieve += 1. total_latency += zero-extended (clk_counter - timestamp) mod 2^TS_W, so timestamp wrap is handled.
- Counters wrap at 2^64.

Test Plan:
- NUM_NODES=4, ROUTER_ID=1: flit dst=3 on link_east_in at edge 0, no stall -> link_west_out = flit with valid 1 after edge 1; link_east_out = 0.
- Inject dst=2 (d=1) -> east; dst=0 (d=3) -> west; dst=3 (d=2, tie) -> east; dst=1 -> eject_valid, total_packet_recieve=1.
- Hold backpressure_west_rd=1; stream 4 flits on link_east_in; BUFFER_SIZE=4, threshold 2 -> backpressure_east_wr=1 after the 2nd write. 5th flit sent while full -> total_packet_dropped=1; release stall -> 4 flits leave in order.
- ARB_MODE=1: through and local both target east every cycle for 6 cycles -> grants alternate T,L,T,L,T,L. ARB_MODE=0 -> 6 through grants.
- Eject flit timestamp=0xFFFE, clk_counter=0x0003 at handshake, eject_ready low for 3 cycles first -> eject_packet stable while stalled; total_latency += 5.
- Assert rst_n low with FIFOs half full and eject_valid=1 -> all outputs and counters 0 immediately; no stale flit after release.
